mode4_tree_sequencer: RTL and testbench
=======================================

// Module: mode4_tree_sequencer
// PURPOSE
//  Sequences one mode-4 adder tree (4 inputs/beat, 3 registered stages, stage0 accumulates into outp).
//  Accepts a start command with a beat count, pulls beats from the input buffer via valid/ready.
//  Drives the per-stage run enables with correct pipeline alignment, and clears the tree before each reduction.
//  Signals done when outp holds the final sum. Sits between the attention-layer buffer read logic and mode4_adder_tree.
// PARAMETERS
//  LEN_WIDTH   5   width of beat-count input; max reduction = 2**LEN_WIDTH-1 beats (4 words/beat)
//  PERF_WIDTH  16  width of stall counter (used only with MODE4_SEQ_PERF_EN)
// PORTS
//  clk               input   1           clock
//  reset             input   1           synchronous, active-high reset
//  start             input   1           start pulse; sampled only in IDLE
//  num_beats         input   LEN_WIDTH   beats to reduce; latched on accepted start
//  in_valid          input   1           input buffer presents inp0..inp3 this cycle
//  in_ready          output  1           sequencer accepts a beat this cycle
//  tree_clr          output  1           one-cycle clear to tree registers (OR'd with reset at tree)
//  mode4_stage2_run  output  1           tree stage2 enable
//  mode4_stage1_run  output  1           tree stage1 enable
//  mode4_stage0_run  output  1           tree stage0 (accumulate) enable
//  busy              output  1           high in CLEAR/FEED/DRAIN
//  done              output  1           one-cycle pulse: tree outp is final
//  result_valid      output  1           high from done until next accepted start
//  stall_cycles      output  PERF_WIDTH  FEED cycles with in_valid=0 (0 if feature off)
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; beat counter, valid pipe and stall counter cleared. Reset mid-operation aborts immediately, no done.
//  - States: IDLE -> CLEAR (start=1) -> FEED (num_beats!=0) | DONE (num_beats==0) -> DRAIN (last beat accepted) -> DONE -> IDLE.
//  - IDLE: start accepted; num_beats latched; result_valid cleared same edge.
//  - CLEAR: tree_clr=1 for exactly one cycle; no run enables.
//  - FEED: in_ready=1; accept = in_valid & in_ready; mode4_stage2_run = accept (same cycle, combinational).
//  - Valid pipe: v1 <= accept, v2 <= v1; mode4_stage1_run = v1, mode4_stage0_run = v2.
//    A beat accepted in cycle t reaches stage1 in t+1 and accumulates in t+2.
//  - Stalls (in_valid=0) create bubbles; the held stage registers are not re-consumed because run follows valid only.
//  - Remaining-count decrements per accept. Accepting the last beat moves to DRAIN; in_ready=0 from then on.
//  - DRAIN: exactly 2 cycles, letting v1/v2 flush. DONE: done=1 for one cycle (cycle t_last+3); result_valid set; -> IDLE.
//  - start while busy/DONE is ignored. in_valid outside FEED is ignored.
//  - Zero-beat reduction: CLEAR then DONE; outp=0.
//  - Arithmetic is owned by the tree (16-bit add; carry-out saturates to 16'h7000). The sequencer does not inspect data.
//  - Latency, start to done with no stalls: N beats -> N+4 cycles (CLEAR 1, FEED N, DRAIN 2, DONE 1).
// CONFIGURATION
//  MODE4_SEQ_PERF_EN defined: stall_cycles counts FEED cycles with in_valid=0.
//    Cleared on accepted start; saturates at all-ones; held after done.
//  Undefined: no counter logic; stall_cycles tied to 0.
// STRUCTURE
//  Shared defines header: state encodings (IDLE/CLEAR/FEED/DRAIN/DONE, 3-bit), DATAWIDTH, NUM(=4) words per beat.
//  Sub-module mode4_valid_pipe: 2-deep valid shift register (in: accept; out: v1, v2; sync clear on reset).
//  Top holds the FSM, beat counter and optional perf counter; a bench instantiates it together with mode4_adder_tree.
// TESTING
//  1. num_beats=16, each beat inp=1,2,3,4, in_valid always 1 -> done at cycle 20 after start, outp=16'h00A0, stall_cycles=0.
//  2. Same data, in_valid low on every other FEED cycle -> outp=16'h00A0, done at cycle 36 after start, stall_cycles=16 (PERF_EN).
//  3. num_beats=0 -> tree_clr pulse, done 2 cycles after start, outp=0, no run enables ever asserted.
//  4. Two back-to-back reductions (3 beats of 0x10 each word, then 2 beats of 0x1) -> second outp=16'h0008; first sum (16'h00C0) cleared by tree_clr.
//  5. reset asserted during FEED -> next cycle all outputs 0, state IDLE, no done; a later start works normally.
//  6. start pulsed while busy -> ignored, num_beats unchanged; inputs 0x4000 x4 for 1 beat -> outp=16'h7000 (tree saturation), done as normal.

Source files
------------

// File: rtl/mode4_tree_sequencer_pkg.sv
// Shared definitions for the mode-4 adder tree sequencer.
// State encodings, tree data width and words per beat.
package mode4_tree_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } seq_state_t;

    localparam int DATAWIDTH    = 16;
    localparam int NUM          = 4;
    localparam int DRAIN_CYCLES = 2;

    // True in the states that hold the tree for a reduction
    function automatic logic state_busy(input seq_state_t s);
        return (s == S_CLEAR) || (s == S_FEED) || (s == S_DRAIN);
    endfunction

endpackage

// File: rtl/mode4_valid_pipe.sv
// Two-deep valid shift register that aligns the stage1/stage0
// tree enables with a beat accepted into stage2.
module mode4_valid_pipe (
    input  logic clk,
    input  logic reset,
    input  logic accept,
    output logic v1,
    output logic v2
);

    // Shift accept down the pipe; reset flushes any beat in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= accept;
            v2 <= v1;
        end
    end

endmodule

// File: rtl/mode4_tree_sequencer.sv
// Sequencer for one mode-4 adder tree: clear, feed, drain, done.
// Optional stall counter enabled with MODE4_SEQ_PERF_EN.
module mode4_tree_sequencer
    import mode4_tree_sequencer_pkg::*;
#(
    parameter int LEN_WIDTH  = 5,
    parameter int PERF_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  num_beats,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  tree_clr,
    output logic                  mode4_stage2_run,
    output logic                  mode4_stage1_run,
    output logic                  mode4_stage0_run,
    output logic                  busy,
    output logic                  done,
    output logic                  result_valid,
    output logic [PERF_WIDTH-1:0] stall_cycles
);

    seq_state_t           state;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 drain_cnt;
    logic                 accept;
    logic                 v1;
    logic                 v2;
    logic                 last_beat;

    // in_ready is only ever high in FEED, so this gates stray in_valid
    assign accept           = in_valid & in_ready;
    assign last_beat        = (remaining == LEN_WIDTH'(1));
    assign mode4_stage2_run = accept;
    assign mode4_stage1_run = v1;
    assign mode4_stage0_run = v2;

    mode4_valid_pipe u_vpipe (
        .clk    (clk),
        .reset  (reset),
        .accept (accept),
        .v1     (v1),
        .v2     (v2)
    );

    // Main FSM with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            remaining    <= '0;
            drain_cnt    <= 1'b0;
            in_ready     <= 1'b0;
            tree_clr     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            tree_clr <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_CLEAR;
                        remaining    <= num_beats;
                        tree_clr     <= 1'b1;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (remaining == '0) begin
                        state        <= S_DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        result_valid <= 1'b1;
                    end else begin
                        state    <= S_FEED;
                        in_ready <= 1'b1;
                    end
                end
                S_FEED: begin
                    if (accept) begin
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (last_beat) begin
                            state     <= S_DRAIN;
                            in_ready  <= 1'b0;
                            drain_cnt <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt == 1'(DRAIN_CYCLES - 1)) begin
                        state        <= S_DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        result_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef MODE4_SEQ_PERF_EN
    logic [PERF_WIDTH-1:0] stall_q;

    // Count FEED cycles starved by the buffer, saturating at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (state == S_IDLE && start) begin
            stall_q <= '0;
        end else if (state == S_FEED && !in_valid && !(&stall_q)) begin
            stall_q <= stall_q + PERF_WIDTH'(1);
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mode4_tree_sequencer.sv
// Directed bench: sequencer driving a behavioural mode-4 tree.
// Expected sums and cycle counts are hand-computed constants.
module tb_mode4_tree_sequencer;
    import mode4_tree_sequencer_pkg::*;

    localparam int LW = 5;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] num_beats;
    logic          in_valid;
    logic          in_ready;
    logic          tree_clr;
    logic          s2_run;
    logic          s1_run;
    logic          s0_run;
    logic          busy;
    logic          done;
    logic          result_valid;
    logic [PW-1:0] stall_cycles;

    logic [DATAWIDTH-1:0] inp [NUM];
    logic [DATAWIDTH-1:0] s2a, s2b, s1, outp;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mode4_tree_sequencer #(
        .LEN_WIDTH  (LW),
        .PERF_WIDTH (PW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .num_beats        (num_beats),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .tree_clr         (tree_clr),
        .mode4_stage2_run (s2_run),
        .mode4_stage1_run (s1_run),
        .mode4_stage0_run (s0_run),
        .busy             (busy),
        .done             (done),
        .result_valid     (result_valid),
        .stall_cycles     (stall_cycles)
    );

    function automatic logic [15:0] sat_add(input logic [15:0] a,
                                            input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'h7000 : s[15:0];
    endfunction

    // Behavioural tree: stage2 pair sums, stage1 total, stage0 accumulate
    always @(posedge clk) begin
        if (reset || tree_clr) begin
            s2a  <= '0;
            s2b  <= '0;
            s1   <= '0;
            outp <= '0;
        end else begin
            if (s2_run) begin
                s2a <= sat_add(inp[0], inp[1]);
                s2b <= sat_add(inp[2], inp[3]);
            end
            if (s1_run) s1 <= sat_add(s2a, s2b);
            if (s0_run) outp <= sat_add(outp, s1);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One reduction; optional alternate stalls and a start poke while busy
    task automatic run(input int n, input logic [15:0] w, input bit stall,
                       input int poke_at, output int done_at,
                       output int runs, output int clrs);
        int cyc;
        int f;
        @(negedge clk);
        for (int i = 0; i < NUM; i++) inp[i] = w;
        start     = 1'b1;
        num_beats = LW'(n);
        in_valid  = 1'b0;
        cyc       = 0;
        f         = 0;
        done_at   = -1;
        runs      = 0;
        clrs      = 0;
        while (cyc < 200 && done_at < 0) begin
            @(negedge clk);
            cyc++;
            start = (cyc == poke_at);
            if (start) num_beats = LW'(n + 5);
            if (done) done_at = cyc;
            if (tree_clr) clrs++;
            in_valid = stall ? f[0] : 1'b1;
            if (in_ready) f++;
            #1;
            if (s2_run || s1_run || s0_run) runs++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    int d, r, c;
    logic [PW-1:0] exp_stall;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        num_beats = '0;
        in_valid  = 1'b0;
        for (int i = 0; i < NUM; i++) inp[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rv", result_valid, 0);
        check("rst_clr", tree_clr, 0);
        check("rst_stall", stall_cycles, 0);
        reset = 1'b0;

        // 1: 16 beats of 1,2,3,4 with no stalls
        @(negedge clk);
        inp[0] = 16'd1; inp[1] = 16'd2; inp[2] = 16'd3; inp[3] = 16'd4;
        start = 1'b1; num_beats = 5'd16; in_valid = 1'b1;
        d = -1;
        for (int cyc = 1; cyc <= 40 && d < 0; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) d = cyc;
        end
        check("t1_done_at", d, 20);
        check("t1_outp", outp, 16'h00A0);
        check("t1_stall", stall_cycles, 0);
        check("t1_rv", result_valid, 1);
        check("t1_busy", busy, 0);

        // 2: same data, in_valid low on every other FEED cycle
        for (int i = 0; i < NUM; i++) inp[i] = 16'(i + 1);
        begin
            int cyc;
            int f;
            @(negedge clk);
            start = 1'b1; num_beats = 5'd16; in_valid = 1'b0;
            cyc = 0; f = 0; d = -1;
            while (cyc < 100 && d < 0) begin
                @(negedge clk);
                cyc++;
                start = 1'b0;
                if (done) d = cyc;
                in_valid = f[0];
                if (in_ready) f++;
            end
            in_valid = 1'b0;
        end
`ifdef MODE4_SEQ_PERF_EN
        exp_stall = 16'd16;
`else
        exp_stall = 16'd0;
`endif
        check("t2_done_at", d, 36);
        check("t2_outp", outp, 16'h00A0);
        check("t2_stall", stall_cycles, exp_stall);
        repeat (3) @(negedge clk);
        check("t2_stall_hold", stall_cycles, exp_stall);
        check("t2_rv_hold", result_valid, 1);

        // 3: zero-beat reduction
        run(0, 16'h0000, 1'b0, -1, d, r, c);
        check("t3_done_at", d, 2);
        check("t3_outp", outp, 16'h0000);
        check("t3_runs", r, 0);
        check("t3_clr", c, 1);

        // 4: back-to-back reductions, tree cleared in between
        run(3, 16'h0010, 1'b0, -1, d, r, c);
        check("t4a_done_at", d, 7);
        check("t4a_outp", outp, 16'h00C0);
        run(2, 16'h0001, 1'b0, -1, d, r, c);
        check("t4b_done_at", d, 6);
        check("t4b_outp", outp, 16'h0008);
        check("t4b_clr", c, 1);

        // 5: reset during FEED aborts without done
        @(negedge clk);
        for (int i = 0; i < NUM; i++) inp[i] = 16'h0001;
        start = 1'b1; num_beats = 5'd16; in_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_feeding", in_ready, 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("t5_ready", in_ready, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_rv", result_valid, 0);
        check("t5_runs", {s2_run, s1_run, s0_run}, 0);
        check("t5_stall", stall_cycles, 0);
        reset = 1'b0;
        c = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) c++;
        end
        check("t5_quiet", c, 0);
        run(2, 16'h0002, 1'b0, -1, d, r, c);
        check("t5_after_done", d, 6);
        check("t5_after_outp", outp, 16'h0010);

        // 6: start poked while busy is ignored; tree saturates
        run(1, 16'h4000, 1'b0, 2, d, r, c);
        check("t6_done_at", d, 5);
        check("t6_outp", outp, 16'h7000);
        @(negedge clk);
        check("t6_idle_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
